shop_buyer: RTL and testbench

Player-side purchase agent that drives the shop's buy interface. Queues action orders from game logic, holds the player's credit wallet, issues one buy request per order, captures the shop's combinational verdict and registered credit/grant return, and reports a per-order status. Sits between player control logic and the shop, owning the `buy_valid`/`action_number`/`credit_in` side of that interface.

---
 rtl/shop_pkg.sv | 40 ++++
 rtl/shop_order_fifo.sv | 45 ++++
 rtl/shop_buyer.sv | 143 ++++++++++++++
 tb/tb_shop_buyer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shop_pkg.sv
// Shared shop/buyer definitions: action and status codes, FSM states and the
// completion record that the buyer latches between ISSUE and SETTLE.
package shop_pkg;

    localparam int unsigned CREDIT_W    = 10;
    localparam int unsigned NUM_ACTIONS = 5;
    localparam int unsigned ACT_W       = 3;
    localparam int unsigned ST_W        = 2;
    localparam int unsigned OK_W        = 8;

    localparam logic [ACT_W-1:0] ACT_KICK  = 3'd0;
    localparam logic [ACT_W-1:0] ACT_PUNCH = 3'd1;
    localparam logic [ACT_W-1:0] ACT_LEFT  = 3'd2;
    localparam logic [ACT_W-1:0] ACT_RIGHT = 3'd3;
    localparam logic [ACT_W-1:0] ACT_WAIT  = 3'd4;

    typedef enum logic [ST_W-1:0] {
        ST_OK      = 2'd0,
        ST_INVALID = 2'd1,
        ST_CREDIT  = 2'd2,
        ST_STOCK   = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_SETTLE = 2'd2
    } state_e;

    typedef struct packed {
        logic [ACT_W-1:0] action;
        status_e          status;
    } result_t;

    // Grant the shop must return for a successful purchase of action a.
    function automatic logic [NUM_ACTIONS-1:0] grant_mask(input logic [ACT_W-1:0] a);
        return {{(NUM_ACTIONS-1){1'b0}}, 1'b1} << a;
    endfunction

endpackage

// File: rtl/shop_order_fifo.sv
// Small synchronous order FIFO with wrap-bit pointers; push ignored when full,
// pop ignored when empty.
module shop_order_fifo #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign dout_o  = mem_q[rd_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= din_i;
                wr_q                <= wr_q + (AW+1)'(1);
            end
            if (do_pop) rd_q <= rd_q + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/shop_buyer.sv
// Player-side purchase agent: queues orders, owns the wallet, issues one buy
// per order to the shop and reports a per-order completion status.
module shop_buyer
    import shop_pkg::*;
#(
    parameter int unsigned INIT_CREDIT = 500,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic [ACT_W-1:0]       req_action,
    output logic                   req_ready,
    input  logic                   earn_valid,
    input  logic [CREDIT_W-1:0]    earn_amount,
    output logic                   earn_ready,
    output logic                   buy_valid,
    output logic [ACT_W-1:0]       action_number,
    output logic [CREDIT_W-1:0]    credit_in,
    input  logic                   purchase_success,
    input  logic                   err_invalid_action,
    input  logic                   err_credit,
    input  logic                   err_out_of_stock,
    input  logic [CREDIT_W-1:0]    credit_out,
    input  logic [NUM_ACTIONS-1:0] grant_onehot,
    output logic                   done_valid,
    output logic [ACT_W-1:0]       done_action,
    output logic [ST_W-1:0]        done_status,
    output logic [CREDIT_W-1:0]    wallet,
    output logic [OK_W-1:0]        ok_count,
    output logic                   protocol_err
);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] wallet_q, wallet_d;
    result_t             res_q, res_d;
    result_t             done_q, done_d;
    logic                done_valid_q, done_valid_d;
    logic [OK_W-1:0]     ok_q, ok_d;
    logic                perr_q, perr_d;

    logic                fifo_pop_c;
    logic                fifo_full_c;
    logic                fifo_empty_c;
    logic [ACT_W-1:0]    fifo_head_c;
    logic [CREDIT_W:0]   earn_sum_c;

    shop_order_fifo #(
        .WIDTH (ACT_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (req_valid && req_ready),
        .din_i   (req_action),
        .pop_i   (fifo_pop_c),
        .dout_o  (fifo_head_c),
        .full_o  (fifo_full_c),
        .empty_o (fifo_empty_c)
    );

    assign earn_sum_c = {1'b0, wallet_q} + {1'b0, earn_amount};

    // State register; async reset also discards any in-flight order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wallet_q     <= CREDIT_W'(INIT_CREDIT);
            res_q        <= '0;
            done_q       <= '0;
            done_valid_q <= 1'b0;
            ok_q         <= '0;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wallet_q     <= wallet_d;
            res_q        <= res_d;
            done_q       <= done_d;
            done_valid_q <= done_valid_d;
            ok_q         <= ok_d;
            perr_q       <= perr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wallet_d     = wallet_q;
        res_d        = res_q;
        done_d       = done_q;
        done_valid_d = 1'b0;
        ok_d         = ok_q;
        perr_d       = perr_q;
        fifo_pop_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (earn_valid) begin
                    wallet_d = earn_sum_c[CREDIT_W] ? '1 : earn_sum_c[CREDIT_W-1:0];
                end else if (!fifo_empty_c) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Shop verdict is combinational on buy_valid; a silent shop is a protocol fault.
                fifo_pop_c   = 1'b1;
                res_d.action = fifo_head_c;
                if (purchase_success)        res_d.status = ST_OK;
                else if (err_invalid_action) res_d.status = ST_INVALID;
                else if (err_credit)         res_d.status = ST_CREDIT;
                else if (err_out_of_stock)   res_d.status = ST_STOCK;
                else begin
                    res_d.status = ST_INVALID;
                    perr_d       = 1'b1;
                end
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                // Shop echoes the unchanged credit on failure, so always adopt it.
                wallet_d = credit_out;
                if (res_q.status == ST_OK) begin
                    if (grant_onehot != grant_mask(res_q.action)) perr_d = 1'b1;
                    if (ok_q != '1) ok_d = ok_q + OK_W'(1);
                end
                done_valid_d = 1'b1;
                done_d       = res_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready     = !fifo_full_c;
    assign earn_ready    = (state_q == S_IDLE);
    assign buy_valid     = (state_q == S_ISSUE);
    assign action_number = buy_valid ? fifo_head_c : '0;
    assign credit_in     = wallet_q;
    assign wallet        = wallet_q;
    assign done_valid    = done_valid_q;
    assign done_action   = done_q.action;
    assign done_status   = done_q.status;
    assign ok_count      = ok_q;
    assign protocol_err  = perr_q;

endmodule

// File: tb/tb_shop_buyer.sv
// Bench for shop_buyer: behavioural shop plus an order-level reference model
// that predicts every output cycle by cycle from push/earn history.
module tb_shop_buyer;
    import shop_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, earn_valid, earn_ready;
    logic [2:0] req_action, action_number, done_action;
    logic [9:0] earn_amount, credit_in, credit_out, wallet;
    logic       buy_valid, purchase_success, err_invalid_action, err_credit, err_out_of_stock;
    logic [4:0] grant_onehot;
    logic       done_valid, protocol_err;
    logic [1:0] done_status;
    logic [7:0] ok_count;

    always #5 clk = ~clk;

    shop_buyer #(.INIT_CREDIT(500), .QUEUE_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_action(req_action), .req_ready(req_ready),
        .earn_valid(earn_valid), .earn_amount(earn_amount), .earn_ready(earn_ready),
        .buy_valid(buy_valid), .action_number(action_number), .credit_in(credit_in),
        .purchase_success(purchase_success), .err_invalid_action(err_invalid_action),
        .err_credit(err_credit), .err_out_of_stock(err_out_of_stock),
        .credit_out(credit_out), .grant_onehot(grant_onehot),
        .done_valid(done_valid), .done_action(done_action), .done_status(done_status),
        .wallet(wallet), .ok_count(ok_count), .protocol_err(protocol_err)
    );

    // Behavioural shop
    int   price [8];
    int   stock_init [8];
    int   stock [8];
    logic shop_mute;

    always_comb begin
        purchase_success   = 1'b0;
        err_invalid_action = 1'b0;
        err_credit         = 1'b0;
        err_out_of_stock   = 1'b0;
        if (buy_valid && !shop_mute) begin
            if (action_number > 3'd4)                  err_invalid_action = 1'b1;
            else if (int'(credit_in) < price[action_number]) err_credit   = 1'b1;
            else if (stock[action_number] == 0)        err_out_of_stock   = 1'b1;
            else                                       purchase_success   = 1'b1;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_out   <= '0;
            grant_onehot <= '0;
            for (int i = 0; i < 8; i++) stock[i] <= stock_init[i];
        end else begin
            grant_onehot <= '0;
            if (buy_valid) begin
                credit_out <= purchase_success ? credit_in - 10'(price[action_number]) : credit_in;
                if (purchase_success) begin
                    grant_onehot          <= 5'(1) << action_number;
                    stock[action_number]  <= stock[action_number] - 1;
                end
            end
        end
    end

    // Reference model: orders in push order with their predicted issue cycle and outcome
    typedef struct {
        int         push;
        int         issue;
        logic [2:0] act;
        logic [1:0] st;
        int         w_after;
        int         ok_after;
        bit         perr;
    } ord_t;

    ord_t oq[$];
    int   cyc, last_issue, proj_wallet, proj_ok, pstock[8];
    int   exp_wallet, exp_ok, earn_eff, earn_val;
    bit   exp_perr;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    function automatic int fifo_count(input int c);
        int n = 0;
        foreach (oq[i]) if (oq[i].push < c && oq[i].issue >= c) n++;
        return n;
    endfunction

    function automatic bit can_earn();
        return fifo_count(cyc) == 0 && cyc >= last_issue + 2;
    endfunction

    task automatic model_reset();
        oq.delete();
        cyc = 0; last_issue = -100;
        proj_wallet = 500; exp_wallet = 500;
        proj_ok = 0; exp_ok = 0; exp_perr = 0; earn_eff = -1;
        for (int i = 0; i < 8; i++) pstock[i] = stock_init[i];
    endtask

    task automatic compare();
        bit eb = 0, ed = 0, busy = 0;
        int ea = 0, da = 0, ds = 0;
        if (earn_eff == cyc) exp_wallet = earn_val;
        foreach (oq[i]) begin
            if (oq[i].issue == cyc) begin eb = 1; ea = oq[i].act; end
            if (oq[i].issue == cyc || oq[i].issue + 1 == cyc) busy = 1;
            if (oq[i].perr && oq[i].issue + 1 == cyc) exp_perr = 1;
            if (oq[i].issue + 2 == cyc) begin
                ed = 1; da = oq[i].act; ds = oq[i].st;
                exp_wallet = oq[i].w_after; exp_ok = oq[i].ok_after;
            end
        end
        chk("buy_valid", buy_valid, eb);
        chk("action_number", action_number, ea);
        chk("credit_in", credit_in, exp_wallet);
        chk("wallet", wallet, exp_wallet);
        chk("earn_ready", earn_ready, !busy);
        chk("req_ready", req_ready, fifo_count(cyc) < DEPTH);
        chk("done_valid", done_valid, ed);
        if (ed) begin
            chk("done_action", done_action, da);
            chk("done_status", done_status, ds);
        end
        chk("ok_count", ok_count, exp_ok);
        chk("protocol_err", protocol_err, exp_perr);
        while (oq.size() > 0 && oq[0].issue + 2 <= cyc) void'(oq.pop_front());
    endtask

    task automatic tick(input bit rv, input int ra, input bit ev, input int ea, output bit acc);
        ord_t o;
        bit   ev_ok;
        ev_ok       = ev && can_earn();
        req_valid   = rv;
        req_action  = 3'(ra);
        earn_valid  = ev_ok;
        earn_amount = 10'(ea);
        if (ev_ok) begin
            proj_wallet = (proj_wallet + ea > 1023) ? 1023 : proj_wallet + ea;
            earn_eff    = cyc + 1;
            earn_val    = proj_wallet;
        end
        acc = rv && (fifo_count(cyc) < DEPTH);
        if (acc) begin
            o.push     = cyc;
            o.issue    = (cyc + 2 > last_issue + 3) ? cyc + 2 : last_issue + 3;
            last_issue = o.issue;
            o.act      = 3'(ra);
            o.perr     = 0;
            if (shop_mute) begin
                o.st = 2'd1; o.perr = 1;
            end else if (ra > 4) o.st = 2'd1;
            else if (proj_wallet < price[ra]) o.st = 2'd2;
            else if (pstock[ra] == 0) o.st = 2'd3;
            else begin
                o.st = 2'd0;
                proj_wallet -= price[ra];
                pstock[ra]--;
                if (proj_ok < 255) proj_ok++;
            end
            o.w_after  = proj_wallet;
            o.ok_after = proj_ok;
            oq.push_back(o);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        compare();
    endtask

    task automatic idle();
        bit a;
        tick(0, 0, 0, 0, a);
    endtask

    task automatic push(input int ra);
        bit a;
        tick(1, ra, 0, 0, a);
    endtask

    task automatic earn(input int amt);
        bit a;
        tick(0, 0, 1, amt, a);
    endtask

    task automatic run_to(input int c);
        while (cyc < c) idle();
    endtask

    task automatic finish_reset();
        req_valid = 0; earn_valid = 0; req_action = '0; earn_amount = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
        compare();
    endtask

    task automatic do_reset();
        rst = 1;
        finish_reset();
    endtask

    initial begin
        bit acc;
        int k;
        rst = 1; shop_mute = 0;
        req_valid = 0; earn_valid = 0; req_action = '0; earn_amount = '0;
        price      = '{600, 100, 250, 50, 0, 0, 0, 0};
        stock_init = '{10, 10, 10, 10, 5, 0, 0, 0};

        // Reset state
        do_reset();
        chk("rst_wallet", wallet, 500);
        chk("rst_buy_valid", buy_valid, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_earn_ready", earn_ready, 1);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_done_status", done_status, 0);

        // Single successful purchase latency
        push(1);
        run_to(2);
        chk("t1_buy_at_2", buy_valid, 1);
        chk("t1_action_at_2", action_number, 1);
        run_to(4);
        chk("t1_done_at_4", done_valid, 1);
        chk("t1_status", done_status, 0);
        chk("t1_action", done_action, 1);
        chk("t1_wallet", wallet, 400);
        chk("t1_ok", ok_count, 1);

        // Invalid action code
        do_reset();
        push(5);
        run_to(4);
        chk("t2_status", done_status, 1);
        chk("t2_wallet", wallet, 500);
        chk("t2_perr", protocol_err, 0);

        // Insufficient credit, then top-up and retry
        do_reset();
        push(0);
        run_to(4);
        chk("t3_status_credit", done_status, 2);
        chk("t3_wallet_kept", wallet, 500);
        earn(200);
        chk("t3_wallet_earned", wallet, 700);
        push(0);
        run_to(9);
        chk("t3_done_retry", done_valid, 1);
        chk("t3_status_ok", done_status, 0);
        chk("t3_wallet_after", wallet, 100);

        // Queue full and out-of-stock on the sixth order
        do_reset();
        k = 0;
        while (k < 6) begin
            if (cyc == 5) chk("t4_full_at_5", req_ready, 0);
            tick(1, 4, 0, 0, acc);
            if (acc) k++;
        end
        run_to(16);
        chk("t4_fifth_status", done_status, 0);
        run_to(19);
        chk("t4_sixth_done", done_valid, 1);
        chk("t4_sixth_status", done_status, 3);
        chk("t4_ok", ok_count, 5);

        // Saturating earn, then reset mid-ISSUE
        do_reset();
        earn(1000);
        chk("t5_wallet_sat", wallet, 1023);
        push(2);
        run_to(3);
        chk("t5_buy_before_rst", buy_valid, 1);
        rst = 1;
        #1;
        chk("t5_buy_async_drop", buy_valid, 0);
        chk("t5_fifo_empty", req_ready, 1);
        chk("t5_wallet_reset", wallet, 500);
        finish_reset();
        run_to(5);
        chk("t5_no_done", done_valid, 0);

        // Silent shop sets the sticky protocol error
        do_reset();
        shop_mute = 1;
        push(3);
        run_to(4);
        chk("t6_status", done_status, 1);
        chk("t6_perr", protocol_err, 1);
        shop_mute = 0;
        push(3);
        run_to(8);
        chk("t6_status_ok", done_status, 0);
        chk("t6_wallet", wallet, 450);
        chk("t6_perr_sticky", protocol_err, 1);

        // Randomised traffic against the model
        stock_init = '{3, 12, 12, 12, 6, 0, 0, 0};
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            int ra;
            ra = ($urandom % 10 < 8) ? int'($urandom % 5) : 5 + int'($urandom % 3);
            tick(($urandom % 3) == 0, ra, ($urandom % 6) == 0, int'($urandom % 400), acc);
        end
        for (int n = 0; n < 16; n++) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
